// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked carry-pipelined add/sub with Y86 flags.
// Build option ADDSUB_SAT_EN clamps overflowed results to the signed limit.
module pipelined_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cf
);

    localparam int CHUNK = WIDTH / STAGES;

    generate
        if (WIDTH % STAGES != 0) begin : g_bad_cfg
            $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
        end
    endgenerate

    // registered state leaving stage k
    logic [WIDTH-1:0] ra [STAGES];
    logic [WIDTH-1:0] rb [STAGES];
    logic [WIDTH-1:0] rr [STAGES];
    logic             rc [STAGES];
    logic             rs [STAGES];
    logic             rv [STAGES];

    // combinational view entering stage k
    logic [WIDTH-1:0] xa [STAGES];
    logic [WIDTH-1:0] xb [STAGES];
    logic [WIDTH-1:0] xr [STAGES];
    logic             xc [STAGES];
    logic             xs [STAGES];
    logic             xv [STAGES];
    logic [WIDTH-1:0] nr [STAGES];
    logic             nc [STAGES];

    logic [CHUNK:0]   t;
    logic [WIDTH-1:0] fres;
    logic             fof;
    logic             fcf;
    logic             advance;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = rv[STAGES-1];

    // route stage inputs and resolve one chunk per stage
    always_comb begin
        t     = '0;
        xa[0] = a;
        xb[0] = sub ? ~b : b;
        xr[0] = '0;
        xc[0] = cin ^ sub;
        xs[0] = sub;
        xv[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            xa[k] = ra[k-1];
            xb[k] = rb[k-1];
            xr[k] = rr[k-1];
            xc[k] = rc[k-1];
            xs[k] = rs[k-1];
            xv[k] = rv[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, xa[k][k*CHUNK +: CHUNK]}
              + {1'b0, xb[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, xc[k]};
            nr[k] = xr[k];
            nr[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
            nc[k] = t[CHUNK];
        end
    end

    // final-stage flags; optional clamp on signed overflow
    always_comb begin
        fres = nr[STAGES-1];
        fof  = (xa[STAGES-1][WIDTH-1] == xb[STAGES-1][WIDTH-1])
            && (fres[WIDTH-1] != xa[STAGES-1][WIDTH-1]);
        fcf  = nc[STAGES-1] ^ xs[STAGES-1];
`ifdef ADDSUB_SAT_EN
        if (fof) begin
            if (xa[STAGES-1][WIDTH-1])
                fres = {1'b1, {(WIDTH-1){1'b0}}};
            else
                fres = {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        fres = fres;
`endif
    end

    // advance all stages together; bubbles never touch data or outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rr[k] <= '0;
                rc[k] <= 1'b0;
                rs[k] <= 1'b0;
                rv[k] <= 1'b0;
            end
            result <= '0;
            zf     <= 1'b0;
            sf     <= 1'b0;
            of     <= 1'b0;
            cf     <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= xv[k];
                if (xv[k]) begin
                    ra[k] <= xa[k];
                    rb[k] <= xb[k];
                    rr[k] <= nr[k];
                    rc[k] <= nc[k];
                    rs[k] <= xs[k];
                end
            end
            if (xv[STAGES-1]) begin
                result <= fres;
                zf     <= (fres == '0);
                sf     <= fres[WIDTH-1];
                of     <= fof;
                cf     <= fcf;
            end
        end
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the 64-bit combinational adder in the Y86 ALU.
- Performs signed add or subtract with carry-in; the operand width is split into STAGES equal chunks, and one chunk resolves per clock.
- Produces the sum plus the Y86 condition flags (ZF, SF, OF) and CF, with a valid/ready handshake on both sides.
- Sits between the execute-stage operand mux and the CC/writeback logic of the pipelined core.

Parameters:
- WIDTH, 64, operand/result width in bits; must be an integer multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); CHUNK = WIDTH/STAGES bits are resolved per stage.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference.
- zf  output  1  result == 0.
- sf  output  1  result[WIDTH-1].
- of  output  1  signed overflow.
- cf  output  1  add: carry-out; sub: borrow-out.

Behaviour:
- Reset: one clk, rst async active-high. Asserting rst immediately clears all stage valid bits, result, zf, sf, of, cf and out_valid to 0. In-flight beats are discarded, not replayed. The first accept is possible on the first clk edge after rst deasserts.
- Arithmetic:
  - Add: result = a + b + cin.
  - Sub: result = a + ~b + ~cin, i.e. a - b - cin.
  - Carry into bit 0 is cin for add and !cin for sub.
  - of = (A_msb == B'_msb) && (result_msb != A_msb), where B' is the inverted b for sub.
  - cf = carry-out for add, !carry-out for sub.
  - zf and sf are derived from the final full result.
- Pipeline:
  - Stage k (0-based) adds bits [k*CHUNK +: CHUNK] using the carry registered from stage k-1.
  - Unprocessed upper operand bits and the sub flag travel with the beat; completed lower result bits are registered forward.
  - Latency is exactly STAGES cycles from accepted input to out_valid, with full throughput of one beat/cycle.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - A beat is accepted on a clk edge with in_valid && in_ready.
  - When advance = 0, every stage holds, including bubbles; bubbles are not collapsed.
  - Outputs stay stable while out_valid && !out_ready.
  - Inputs are ignored when in_valid = 0; a bubble enters stage 0.
- Ordering: results leave in acceptance order; no drops, no duplicates.
- STAGES = 1: single registered adder with latency 1.
- Boundaries:
  - Full pipeline plus out_ready low: in_ready = 0 and nothing moves.
  - out_ready rising with in_valid high in the same cycle: the output beat retires and a new beat is accepted on the same edge.
  - Operand values with X on a bubble must not propagate to flags when out_valid = 0; outputs are held at their last values.
  - Elaboration error (generate-time $error) if WIDTH % STAGES != 0.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when of = 1, result is clamped to the signed limit: 0111..1 if the true result overflowed positive, 1000..0 if negative. of is still reported as 1; zf, sf and cf are computed from the clamped result. The clamp adds no latency, as it is applied in the last stage.
- Undefined: result wraps modulo 2^WIDTH; no clamp logic is present.

Test Plan (WIDTH = 64, STAGES = 4 unless stated):
- Add 0x9DE + 0x1B2B, cin = 0 -> result 0x2509 after exactly 4 cycles; zf = 0, sf = 0, of = 0, cf = 0.
- Add -25 + -44 (0xFFFF_FFFF_FFFF_FFE7 + 0xFFFF_FFFF_FFFF_FFD4) -> result 0xFFFF_FFFF_FFFF_FFBB; sf = 1, cf = 1, of = 0.
- Add 0x7FFF_FFFF_FFFF_FFFF + 1 -> result 0x8000_0000_0000_0000, of = 1, sf = 1. With ADDSUB_SAT_EN -> result 0x7FFF_FFFF_FFFF_FFFF, of = 1, sf = 0.
- Sub 5 - 5, cin = 0 -> result 0, zf = 1, cf = 0. Sub 3 - 5 -> result 0xFFFF_FFFF_FFFF_FFFE, cf = 1, sf = 1.
- Stream 8 back-to-back beats with out_ready low for 3 cycles mid-stream -> in_ready drops while stalled; all 8 results emerge in order and unchanged; no extra out_valid pulses.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid and all outputs go to 0 immediately; no stale beat appears afterwards. Repeat the first scenario with STAGES = 1 (latency 1) and STAGES = 8.
